// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit and its datapath muxes.
// Opcode constants, state encoding, select encodings and the opcode classifier.
package cpu_ctrl_pkg;

  localparam int OPW_C = 6;

  localparam logic [OPW_C-1:0] OP_BEQ  = 6'b100000;
  localparam logic [OPW_C-1:0] OP_BNE  = 6'b100001;
  localparam logic [OPW_C-1:0] OP_JMP  = 6'b100010;
  localparam logic [OPW_C-1:0] OP_LW   = 6'b110000;
  localparam logic [OPW_C-1:0] OP_SW   = 6'b110001;
  localparam logic [OPW_C-1:0] OP_HALT = 6'b111111;

  // Class masks compared against op[5:4].
  localparam logic [1:0] OP_CLASS_R = 2'b00;
  localparam logic [1:0] OP_CLASS_I = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_LD   = 4'd7,
    S_WB_LD    = 4'd8,
    S_MEM_ST   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALUB_REG = 2'b00,
    ALUB_ONE = 2'b01,
    ALUB_IMM = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCS_INC    = 2'b00,
    PCS_BRANCH = 2'b01,
    PCS_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [3:0] {
    OPC_R, OPC_I, OPC_BEQ, OPC_BNE, OPC_JMP, OPC_LW, OPC_SW, OPC_HALT, OPC_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic       select_ins;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    pc_src_e    pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       instr_done;
  } ctrl_t;

  function automatic op_class_e classify(input logic [OPW_C-1:0] op);
    if (op[5:4] == OP_CLASS_R) return OPC_R;
    if (op[5:4] == OP_CLASS_I) return OPC_I;
    case (op)
      OP_BEQ:  return OPC_BEQ;
      OP_BNE:  return OPC_BNE;
      OP_JMP:  return OPC_JMP;
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_HALT: return OPC_HALT;
      default: return OPC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> datapath strobe map for the multicycle control unit.
// Reset forces every strobe low regardless of the current state.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e    state_i,
  input  op_class_e op_class_i,
  input  logic      reset_i,
  output ctrl_t     ctrl_o
);

  always_comb begin
    // NOTE: default every field first so no path through the case leaves a latch.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = ALUB_ONE;
        ctrl_o.pc_src    = PCS_INC;
        ctrl_o.pc_write  = 1'b1;
      end
      // An illegal opcode retires here as a NOP.
      S_DECODE: ctrl_o.instr_done = (op_class_i == OPC_ILLEGAL);
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
      end
      S_EXEC_I, S_MEM_ADDR, S_MEM_LD: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
      end
      S_WB_R: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = ALUB_REG;
        ctrl_o.instr_done = 1'b1;
      end
      S_WB_I: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = ALUB_IMM;
        ctrl_o.instr_done = 1'b1;
      end
      S_WB_LD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_ST: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUB_REG;
        ctrl_o.pc_src        = PCS_BRANCH;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.beq           = (op_class_i == OPC_BEQ);
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src     = PCS_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset_i) ctrl_o = '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM control unit for the multicycle CPU: opcode latch, state sequencing,
// branch-taken debug flag, retired-instruction counter and halt indication.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            beq_flag,
  output logic            select_ins,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            beq,
  output logic [1:0]      pc_src,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_taken,
  output logic            instr_done,
  output logic [CNTW-1:0] instr_count,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            branch_taken_q, branch_taken_d;
  op_class_e       op_class;
  ctrl_t           ctrl;

  assign op_class = classify(op_q[5:0]);

  ctrl_output_decode u_decode (
    .state_i    (state_q),
    .op_class_i (op_class),
    .reset_i    (reset),
    .ctrl_o     (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          OPC_R:           state_d = S_EXEC_R;
          OPC_I:           state_d = S_EXEC_I;
          OPC_LW, OPC_SW:  state_d = S_MEM_ADDR;
          OPC_BEQ, OPC_BNE: state_d = S_BRANCH;
          OPC_JMP:         state_d = S_JUMP;
          OPC_HALT:        state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op_class == OPC_LW) ? S_MEM_LD : S_MEM_ST;
      S_MEM_LD:   state_d = S_WB_LD;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // The counter wraps silently; instr_done is already low during reset.
  assign count_d        = ctrl.instr_done ? count_q + CNTW'(1) : count_q;
  assign branch_taken_d = (state_q == S_BRANCH) ? (ctrl.beq ? beq_flag : ~beq_flag)
                                                : branch_taken_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q        <= S_FETCH;
      op_q           <= '0;
      count_q        <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      if (state_q == S_FETCH) op_q <= opcode;
      count_q        <= count_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign select_ins    = ctrl.select_ins;
  assign ir_write      = ctrl.ir_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign beq           = ctrl.beq;
  assign pc_src        = ctrl.pc_src;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign instr_done    = ctrl.instr_done;
  assign branch_taken  = branch_taken_q;
  assign instr_count   = count_q;
  assign halted        = (state_q == S_HALT);
  assign state_dbg     = state_q;

endmodule
